// File: rtl/keypad_scan.sv
// keypad_scan: 4x3 matrix keypad scanner with multi-key rejection and debounce,
// producing a one-hot digit bus plus star/hash levels and a new-key pulse.
module keypad_scan #(
    parameter int SCAN_DIV = 4,
    parameter int DEBOUNCE = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_row,
    output logic [2:0] key_col,
    output logic [9:0] keypad,
    output logic       key_star,
    output logic       key_hash,
    output logic       key_valid
);
    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [3:0] NONE = 4'hF;

    logic [3:0]    row_s1, row_s2, rows;
    logic [DW-1:0] div;
    logic [1:0]    col, hits, hits_nx, top_row;
    logic [2:0]    row_cnt, hit_sum;
    logic [3:0]    rec, rec_nx, cand, cand_nx, stable, cnt, cnt_nx, scan_code;
    logic          sample, accept;

    function automatic logic [3:0] key_code(input logic [1:0] c, input logic [1:0] r);
        return (r == 2'd3) ? ((c == 2'd0) ? 4'd10 : (c == 2'd1) ? 4'd0 : 4'd11)
                           : 4'({2'b0, r} * 4'd3 + {2'b0, c} + 4'd1);
    endfunction

    assign key_col = ~(3'b001 << col);

    always_comb begin
        rows      = ~row_s2;
        sample    = div == DW'(SCAN_DIV - 1);
        row_cnt   = {2'b0, rows[0]} + {2'b0, rows[1]} + {2'b0, rows[2]} + {2'b0, rows[3]};
        hit_sum   = {1'b0, hits} + row_cnt;
        hits_nx   = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
        top_row   = rows[3] ? 2'd3 : rows[2] ? 2'd2 : rows[1] ? 2'd1 : 2'd0;
        rec_nx    = (|rows) ? key_code(col, top_row) : rec;
        // More than one hit anywhere in the scan reads as no key.
        scan_code = (hits_nx == 2'd1) ? rec_nx : NONE;
        cand_nx   = scan_code;
        cnt_nx    = (scan_code != cand) ? 4'd1 : (cnt == 4'(DEBOUNCE)) ? cnt : cnt + 4'd1;
        accept    = (cnt_nx == 4'(DEBOUNCE)) && (cand_nx != stable);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_s1    <= 4'hF;
            row_s2    <= 4'hF;
            div       <= '0;
            col       <= 2'd0;
            hits      <= 2'd0;
            rec       <= NONE;
            cand      <= NONE;
            cnt       <= 4'd0;
            stable    <= NONE;
            keypad    <= 10'd0;
            key_star  <= 1'b0;
            key_hash  <= 1'b0;
            key_valid <= 1'b0;
        end else begin
            row_s1    <= key_row;
            row_s2    <= row_s1;
            key_valid <= 1'b0;
            div       <= sample ? '0 : div + DW'(1);
            if (sample) begin
                col <= (col == 2'd2) ? 2'd0 : col + 2'd1;
                if (col == 2'd2) begin
                    hits <= 2'd0;
                    rec  <= NONE;
                    cand <= cand_nx;
                    cnt  <= cnt_nx;
                    if (accept) begin
                        stable    <= cand_nx;
                        keypad    <= (cand_nx < 4'd10) ? (10'b1 << cand_nx) : 10'd0;
                        key_star  <= cand_nx == 4'd10;
                        key_hash  <= cand_nx == 4'd11;
                        key_valid <= cand_nx != NONE;
                    end
                end else begin
                    hits <= hits_nx;
                    rec  <= rec_nx;
                end
            end
        end
    end
endmodule
